// File: rtl/exit_ctrl_regs_if.sv
// Memory-mapped request/response bus used to reach the exit-control registers.
// The master drives requests; the slave grants them and answers one cycle later.
interface exit_ctrl_regs_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req_i;
    logic                  mem_gnt_o;
    logic [ADDR_WIDTH-1:0] mem_addr_i;
    logic                  mem_we_i;
    logic [31:0]           mem_wdata_i;
    logic [3:0]            mem_strb_i;
    logic                  mem_rvalid_o;
    logic [31:0]           mem_rdata_o;

    modport master (
        output mem_req_i, mem_addr_i, mem_we_i, mem_wdata_i, mem_strb_i,
        input  mem_gnt_o, mem_rvalid_o, mem_rdata_o
    );

    modport slave (
        input  mem_req_i, mem_addr_i, mem_we_i, mem_wdata_i, mem_strb_i,
        output mem_gnt_o, mem_rvalid_o, mem_rdata_o
    );
endinterface

// File: rtl/exit_ctrl_regs.sv
// Simulation exit controller: software or per-hart completion writes end the run.
// Optional watchdog countdown is enabled by defining EXIT_CTRL_WATCHDOG_EN.
module exit_ctrl_regs #(
    parameter int          NUM_HARTS      = 1,
    parameter int          ADDR_WIDTH     = 32,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    exit_ctrl_regs_if.slave      bus,
    output logic                 exit_valid_o,
    output logic                 exit_zero_o,
    output logic [31:0]          exit_value_o,
    output logic [2:0]           exit_hart_o,
    output logic                 timeout_o
);
    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_VALUE  = 8'h04;
    localparam logic [7:0] OFF_PASS   = 8'h10;
    localparam logic [7:0] OFF_WDOG   = 8'h30;

    typedef enum logic {RUN, EXITED} state_t;

    state_t                 r_state, w_stateNext;
    logic [NUM_HARTS-1:0]   r_done, w_doneNext;
    logic [31:0]            r_code     [NUM_HARTS];
    logic [31:0]            w_codeNext [NUM_HARTS];
    logic [NUM_HARTS-1:0]   w_hitVec;
    logic [31:0]            r_exitValue, w_exitValue, w_maskValue;
    logic [2:0]             r_exitHart, w_exitHart, w_maskHart;
    logic                   r_exitZero, r_timeout, w_exitTimeout, w_exitEvent;
    logic                   r_rvalid;
    logic [31:0]            r_rdata, w_rdata;
    logic [7:0]             w_off, w_done8;
    logic [3:0]             w_hartIdx;
    logic                   w_accept, w_wrEn, w_hartWr, w_maskExit;
    logic                   w_wdogExpire;
    logic [31:0]            w_wdogCount;
    logic                   w_unusedAddr;

    assign bus.mem_gnt_o    = ~rst_i;
    assign w_accept         = bus.mem_req_i & bus.mem_gnt_o;
    assign w_off            = bus.mem_addr_i[7:0];
    assign w_hartIdx        = w_off[5:2];
    assign w_wrEn           = w_accept & bus.mem_we_i & (bus.mem_strb_i != 4'h0);
    assign w_hartWr         = w_wrEn && (r_state == RUN) && (w_hitVec != '0);
    assign w_unusedAddr     = ^bus.mem_addr_i[ADDR_WIDTH-1:8];

    always_comb begin
        w_hitVec = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            w_hitVec[h] = (w_off[7:6] == 2'b01) && (w_off[1:0] == 2'b00) && (w_hartIdx == 4'(h));
        end
    end

    // Post-write view of the done mask and codes, so a completing write exits in its own cycle.
    always_comb begin
        w_doneNext  = r_done;
        w_maskValue = '0;
        w_maskHart  = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            w_codeNext[h] = r_code[h];
            if (w_hartWr && w_hitVec[h]) begin
                w_doneNext[h] = 1'b1;
                w_codeNext[h] = bus.mem_wdata_i;
            end
        end
        for (int h = NUM_HARTS - 1; h >= 0; h--) begin
            if (w_codeNext[h] != 32'd0) begin
                w_maskValue = w_codeNext[h];
                w_maskHart  = 3'(h);
            end
        end
    end

    assign w_maskExit = w_hartWr && (&w_doneNext);

`ifdef EXIT_CTRL_WATCHDOG_EN
    logic [31:0] r_wdog;
    logic        r_wdogEn;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wdog   <= TIMEOUT_CYCLES;
            r_wdogEn <= (TIMEOUT_CYCLES != 32'd0);
        end else if (w_wrEn && (w_off == OFF_WDOG)) begin
            r_wdog   <= bus.mem_wdata_i;
            r_wdogEn <= (bus.mem_wdata_i != 32'd0);
        end else if ((r_state == RUN) && (r_wdog != 32'd0)) begin
            r_wdog   <= r_wdog - 32'd1;
        end
    end

    assign w_wdogExpire = r_wdogEn && (r_wdog == 32'd0) && !(w_wrEn && (w_off == OFF_WDOG));
    assign w_wdogCount  = r_wdog;
`else
    assign w_wdogExpire = 1'b0;
    assign w_wdogCount  = 32'd0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= RUN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Explicit exit writes outrank mask completion, which outranks watchdog expiry.
    always_comb begin
        w_stateNext   = r_state;
        w_exitEvent   = 1'b0;
        w_exitValue   = '0;
        w_exitHart    = '0;
        w_exitTimeout = 1'b0;
        case (r_state)
            RUN: begin
                if (w_wrEn && (w_off == OFF_VALUE)) begin
                    w_exitEvent = 1'b1;
                    w_exitValue = bus.mem_wdata_i;
                end else if (w_wrEn && (w_off == OFF_PASS)) begin
                    w_exitEvent = 1'b1;
                end else if (w_maskExit) begin
                    w_exitEvent = 1'b1;
                    w_exitValue = w_maskValue;
                    w_exitHart  = w_maskHart;
                end else if (w_wdogExpire) begin
                    w_exitEvent   = 1'b1;
                    w_exitValue   = 32'hDEAD_0001;
                    w_exitTimeout = 1'b1;
                end
                if (w_exitEvent) begin
                    w_stateNext = EXITED;
                end
            end
            EXITED: w_stateNext = EXITED;
            default: w_stateNext = RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_done      <= '0;
            r_exitValue <= '0;
            r_exitHart  <= '0;
            r_exitZero  <= 1'b0;
            r_timeout   <= 1'b0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_code[h] <= '0;
            end
        end else begin
            r_done <= w_doneNext;
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_code[h] <= w_codeNext[h];
            end
            if (w_exitEvent) begin
                r_exitValue <= w_exitValue;
                r_exitHart  <= w_exitHart;
                r_exitZero  <= (w_exitValue == 32'd0);
                r_timeout   <= w_exitTimeout;
            end
        end
    end

    always_comb begin
        w_done8 = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            w_done8[h] = r_done[h];
        end
        w_rdata = '0;
        case (w_off)
            OFF_STATUS: w_rdata = {16'(NUM_HARTS), 6'd0, r_timeout, (r_state == EXITED), w_done8};
            OFF_VALUE:  w_rdata = r_exitValue;
            OFF_WDOG:   w_rdata = w_wdogCount;
            default: begin
                for (int h = 0; h < NUM_HARTS; h++) begin
                    if (w_hitVec[h]) begin
                        w_rdata = r_code[h];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_accept;
            r_rdata  <= (w_accept && !bus.mem_we_i) ? w_rdata : 32'd0;
        end
    end

    assign bus.mem_rvalid_o = r_rvalid;
    assign bus.mem_rdata_o  = r_rdata;
    assign exit_valid_o     = (r_state == EXITED);
    assign exit_zero_o      = r_exitZero;
    assign exit_value_o     = r_exitValue;
    assign exit_hart_o      = r_exitHart;
    assign timeout_o        = r_timeout;
endmodule

// File: tb/tb_exit_ctrl_regs.sv
// Directed bench for exit_ctrl_regs with four harts and a short watchdog load.
// Watchdog scenarios run when EXIT_CTRL_WATCHDOG_EN is defined; otherwise the tied-off behaviour is checked.
module tb_exit_ctrl_regs;
    localparam int NH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exitValid, exitZero, timeout;
    logic [31:0] exitValue;
    logic [2:0]  exitHart;
    int          checkCount = 0;
    int          passCount  = 0;

    always #5 clk = ~clk;

    exit_ctrl_regs_if #(.ADDR_WIDTH(32)) bus();

    exit_ctrl_regs #(
        .NUM_HARTS(NH),
        .ADDR_WIDTH(32),
        .TIMEOUT_CYCLES(32'd100)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus),
        .exit_valid_o(exitValid),
        .exit_zero_o(exitZero),
        .exit_value_o(exitValue),
        .exit_hart_o(exitHart),
        .timeout_o(timeout)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One bus transfer starting just after a falling edge; returns at the next falling edge,
    // by which time the accepting rising edge has registered the response.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb);
        bus.mem_req_i   = 1'b1;
        bus.mem_we_i    = we;
        bus.mem_addr_i  = addr;
        bus.mem_wdata_i = wdata;
        bus.mem_strb_i  = strb;
        @(negedge clk);
        bus.mem_req_i   = 1'b0;
        bus.mem_we_i    = 1'b0;
        bus.mem_wdata_i = '0;
        bus.mem_strb_i  = '0;
    endtask

    task automatic writeReg(input logic [31:0] addr, input logic [31:0] wdata);
        applyStimulus(1'b1, addr, wdata, 4'hF);
    endtask

    task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] expected);
        applyStimulus(1'b0, addr, 32'd0, 4'h0);
        checkOutput({tag, " rvalid"}, 32'(bus.mem_rvalid_o), 32'd1);
        checkOutput(tag, bus.mem_rdata_o, expected);
    endtask

    task automatic resetDut();
        rst = 1'b1;
        bus.mem_req_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.mem_req_i   = 1'b0;
        bus.mem_we_i    = 1'b0;
        bus.mem_addr_i  = '0;
        bus.mem_wdata_i = '0;
        bus.mem_strb_i  = '0;

        // Values held while reset is asserted
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst gnt", 32'(bus.mem_gnt_o), 32'd0);
        checkOutput("rst rvalid", 32'(bus.mem_rvalid_o), 32'd0);
        checkOutput("rst rdata", bus.mem_rdata_o, 32'd0);
        checkOutput("rst exit_valid", 32'(exitValid), 32'd0);
        checkOutput("rst exit_zero", 32'(exitZero), 32'd0);
        checkOutput("rst exit_value", exitValue, 32'd0);
        checkOutput("rst exit_hart", 32'(exitHart), 32'd0);
        checkOutput("rst timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("gnt after reset", 32'(bus.mem_gnt_o), 32'd1);
        @(negedge clk);

        // Exit with value zero
        writeReg(32'h04, 32'h0);
        checkOutput("wr04 rvalid", 32'(bus.mem_rvalid_o), 32'd1);
        checkOutput("wr04 rdata", bus.mem_rdata_o, 32'd0);
        checkOutput("wr04 exit_valid", 32'(exitValid), 32'd1);
        checkOutput("wr04 exit_zero", 32'(exitZero), 32'd1);
        checkOutput("wr04 exit_value", exitValue, 32'd0);
        @(negedge clk);
        checkOutput("rvalid one cycle", 32'(bus.mem_rvalid_o), 32'd0);

        // Nonzero exit is sticky against a later pass write
        resetDut();
        writeReg(32'h04, 32'h2A);
        checkOutput("2A exit_value", exitValue, 32'h2A);
        checkOutput("2A exit_zero", 32'(exitZero), 32'd0);
        writeReg(32'h10, 32'h0);
        checkOutput("2A sticky value", exitValue, 32'h2A);
        checkOutput("2A sticky zero", 32'(exitZero), 32'd0);
        readCheck("rd value", 32'h04, 32'h2A);
        readCheck("status exited", 32'h00, 32'h0004_0100);

        // Per-hart completion: exit only when the fourth hart reports
        resetDut();
        writeReg(32'h40, 32'd0);
        writeReg(32'h48, 32'd7);
        writeReg(32'h44, 32'd0);
        checkOutput("3 harts no exit", 32'(exitValid), 32'd0);
        readCheck("status partial", 32'h00, 32'h0004_0007);
        writeReg(32'h4C, 32'd3);
        checkOutput("mask exit_valid", 32'(exitValid), 32'd1);
        checkOutput("mask exit_value", exitValue, 32'd7);
        checkOutput("mask exit_hart", 32'(exitHart), 32'd2);
        checkOutput("mask exit_zero", 32'(exitZero), 32'd0);
        readCheck("status full", 32'h00, 32'h0004_010F);
        readCheck("rd code2", 32'h48, 32'd7);
        readCheck("rd code3", 32'h4C, 32'd3);

        // Out-of-range hart ignored, rewrite overwrites, all-zero codes exit with 0
        resetDut();
        writeReg(32'h50, 32'd9);
        readCheck("status hart4 ignored", 32'h00, 32'h0004_0000);
        readCheck("rd hart4", 32'h50, 32'd0);
        writeReg(32'h44, 32'd5);
        readCheck("rd code1 first", 32'h44, 32'd5);
        writeReg(32'h44, 32'd0);
        readCheck("rd code1 rewrite", 32'h44, 32'd0);
        writeReg(32'h40, 32'd0);
        writeReg(32'h48, 32'd0);
        writeReg(32'h4C, 32'd0);
        checkOutput("zero mask valid", 32'(exitValid), 32'd1);
        checkOutput("zero mask value", exitValue, 32'd0);
        checkOutput("zero mask hart", 32'(exitHart), 32'd0);
        checkOutput("zero mask zero", 32'(exitZero), 32'd1);

        // Empty byte strobe is answered but has no effect
        resetDut();
        applyStimulus(1'b1, 32'h04, 32'd5, 4'h0);
        checkOutput("strb0 rvalid", 32'(bus.mem_rvalid_o), 32'd1);
        checkOutput("strb0 no exit", 32'(exitValid), 32'd0);
        writeReg(32'h04, 32'h11);
        checkOutput("after strb0 value", exitValue, 32'h11);
        writeReg(32'h04, 32'h22);
        checkOutput("exited ignores write", exitValue, 32'h11);

        // Back-to-back reads, then reset in the middle of the burst
        resetDut();
        bus.mem_req_i  = 1'b1;
        bus.mem_we_i   = 1'b0;
        bus.mem_addr_i = 32'h00;
        @(negedge clk);
        checkOutput("b2b rvalid 1", 32'(bus.mem_rvalid_o), 32'd1);
        checkOutput("b2b rdata 1", bus.mem_rdata_o, 32'h0004_0000);
        @(negedge clk);
        checkOutput("b2b rvalid 2", 32'(bus.mem_rvalid_o), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid reset rvalid", 32'(bus.mem_rvalid_o), 32'd0);
        bus.mem_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post reset rvalid", 32'(bus.mem_rvalid_o), 32'd0);
        checkOutput("post reset rdata", bus.mem_rdata_o, 32'd0);
        checkOutput("post reset exit", 32'(exitValid), 32'd0);

`ifdef EXIT_CTRL_WATCHDOG_EN
        // Expiry 101 cycles after reset release
        resetDut();
        repeat (100) @(negedge clk);
        checkOutput("wdog not yet", 32'(exitValid), 32'd0);
        @(negedge clk);
        checkOutput("wdog exit_valid", 32'(exitValid), 32'd1);
        checkOutput("wdog timeout", 32'(timeout), 32'd1);
        checkOutput("wdog value", exitValue, 32'hDEAD_0001);
        readCheck("wdog status", 32'h00, 32'h0004_0300);

        // Reload then read current count
        resetDut();
        writeReg(32'h30, 32'd50);
        readCheck("wdog count", 32'h30, 32'd50);

        // Reloaded to 3: expiry registered on the fifth edge
        resetDut();
        writeReg(32'h30, 32'd3);
        repeat (3) @(negedge clk);
        checkOutput("reload not yet", 32'(exitValid), 32'd0);
        @(negedge clk);
        checkOutput("reload expiry", 32'(timeout), 32'd1);

        // Write exit on that same fifth edge wins over expiry
        resetDut();
        writeReg(32'h30, 32'd3);
        repeat (3) @(negedge clk);
        writeReg(32'h04, 32'h55);
        checkOutput("race valid", 32'(exitValid), 32'd1);
        checkOutput("race value", exitValue, 32'h55);
        checkOutput("race timeout", 32'(timeout), 32'd0);

        // Loading zero disables the watchdog
        resetDut();
        writeReg(32'h30, 32'd0);
        repeat (120) @(negedge clk);
        checkOutput("wdog disabled", 32'(exitValid), 32'd0);
        readCheck("wdog disabled count", 32'h30, 32'd0);
`else
        // Without the watchdog the counter register is inert
        resetDut();
        writeReg(32'h30, 32'd3);
        repeat (120) @(negedge clk);
        checkOutput("no wdog exit", 32'(exitValid), 32'd0);
        checkOutput("no wdog timeout", 32'(timeout), 32'd0);
        readCheck("no wdog read", 32'h30, 32'd0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/exit_ctrl_regs.md
EXIT_CTRL_REGS -- requirements
Module: exit_ctrl_regs

Interface
REQ-001 SHALL have parameter NUM_HARTS, default 1, number of per-hart done slots (1..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, width of mem_addr_i.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 32'd1_000_000, watchdog reset load value (32 bits).
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port mem_req_i  input  1  request valid.
REQ-007 SHALL have port mem_gnt_o  output  1  grant; constant 1 outside reset.
REQ-008 SHALL have ports mem_addr_i  input  ADDR_WIDTH; mem_we_i  input  1; mem_wdata_i  input  32; mem_strb_i  input  4.
REQ-009 SHALL have ports mem_rvalid_o  output  1 and mem_rdata_o  output  32  response.
REQ-010 SHALL have ports exit_valid_o  output  1; exit_zero_o  output  1; exit_value_o  output  32; exit_hart_o  output  3; timeout_o  output  1.

Function
REQ-011 SHALL decode only mem_addr_i[7:0]; accepted request = mem_req_i & mem_gnt_o.
REQ-012 SHALL assert mem_rvalid_o exactly 1 cycle after every accepted request (read or write); mem_rdata_o valid with it, 0 for writes and unmapped offsets.
REQ-013 SHALL treat writes with mem_strb_i == 4'h0 as no-ops (still answered via rvalid).
REQ-014 SHALL implement FSM RUN -> EXITED; EXITED is sticky until reset; all exit events in EXITED are ignored.
REQ-015 Write 0x04 in RUN: exit, value = wdata, hart 0.
REQ-016 Write 0x10 in RUN: exit, value = 0, hart 0.
REQ-017 Write 0x40+4*h (h < NUM_HARTS) in RUN: set done[h], store code[h] = wdata; rewrite overwrites code; h >= NUM_HARTS ignored.
REQ-018 When done mask becomes all ones: exit, value = code of lowest-index hart with nonzero code (hart = that index), else value 0, hart 0.
REQ-019 Write 0x40+4*h that completes the mask SHALL exit in the same cycle as the write is accepted.
REQ-020 On exit, exit_valid_o, exit_value_o, exit_zero_o (= value==0), exit_hart_o SHALL update on the clock edge accepting the triggering write (visible next cycle), then hold.
REQ-021 Read 0x00 STATUS: [7:0] done mask, [8] exited, [9] timeout, [31:16] NUM_HARTS.
REQ-022 Read 0x04 returns exit_value_o; read 0x40+4*h returns code[h].

Reset
REQ-023 While rst_i high: FSM = RUN, exit_valid_o = 0, exit_zero_o = 0, exit_value_o = 0, exit_hart_o = 0, timeout_o = 0, mem_gnt_o = 0, mem_rvalid_o = 0, mem_rdata_o = 0, done mask = 0, codes = 0.
REQ-024 Reset asserted mid-transaction SHALL drop any pending rvalid; no response after deassertion.

Configuration
REQ-025 Macro EXIT_CTRL_WATCHDOG_EN defined: 32-bit down-counter loaded with TIMEOUT_CYCLES at reset, decrements each cycle in RUN, stops at 0.
REQ-026 Counter reaching 0 in RUN: exit, value 32'hDEAD_0001, hart 0, timeout_o = 1 (sticky).
REQ-027 Write 0x30 reloads counter with wdata; wdata 0 disables watchdog; read 0x30 returns current count.
REQ-028 A write exit and counter expiry in the same cycle: write exit wins, timeout_o stays 0.
REQ-029 Macro undefined: no counter, timeout_o tied 0, 0x30 writes ignored, reads 0.

Verification
REQ-030 Write 0x04 data 0x0000_0000 -> next cycle exit_valid_o=1, exit_zero_o=1, exit_value_o=0.
REQ-031 Write 0x04 data 0x0000_002A then write 0x10 -> exit_value_o=0x2A, exit_zero_o=0, unchanged by second write.
REQ-032 NUM_HARTS=4; writes 0x40=0, 0x48=7, 0x44=0, 0x4C=3 -> exit only after 4th write, exit_value_o=7, exit_hart_o=2; STATUS read = 0x0004_010F.
REQ-033 WATCHDOG_EN, TIMEOUT_CYCLES=100, no writes -> exit_valid_o rises 101 cycles after reset release (100 decrements + registered update), timeout_o=1, exit_value_o=32'hDEAD_0001.
REQ-034 Read 0x00 back-to-back on 3 cycles -> mem_rvalid_o high on cycles 2-4; rst_i pulsed on cycle 3 -> no rvalid after release, all outputs 0.
REQ-035 Write 0x04 with strb 4'h0 -> rvalid returned, no exit; watchdog and write-exit same cycle -> timeout_o=0, write value reported.
